// File: rtl/l3_trace_dispatch_if.sv
// Trace-command bus between the trace reader, the dispatch block and the L3 cache model.
// The master side is the trace reader / cache pair; the slave side is the dispatch block.
interface l3_trace_dispatch_if #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int OPR_BITS    = 4
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - OFFSET_BITS;

  logic                   in_valid;
  logic                   in_ready;
  logic [OPR_BITS-1:0]    in_opr;
  logic [ADDR_BITS-1:0]   in_addr;
  logic                   out_valid;
  logic                   out_ready;
  logic [OPR_BITS-1:0]    out_opr;
  logic [TAG_BITS-1:0]    out_tag;
  logic [INDEX_BITS-1:0]  out_index;
  logic [OFFSET_BITS-1:0] out_offset;
  logic                   out_is_snoop;
  logic                   clear_done;
  logic                   err_opcode;
  logic [31:0]            cmd_count;
  logic [15:0]            illegal_count;

  modport master (
    output in_valid, in_opr, in_addr, out_ready, clear_done,
    input  in_ready, out_valid, out_opr, out_tag, out_index, out_offset,
           out_is_snoop, err_opcode, cmd_count, illegal_count
  );

  modport slave (
    input  in_valid, in_opr, in_addr, out_ready, clear_done,
    output in_ready, out_valid, out_opr, out_tag, out_index, out_offset,
           out_is_snoop, err_opcode, cmd_count, illegal_count
  );
endinterface

// File: rtl/l3_trace_dispatch.sv
// Buffers trace commands, splits addresses at enqueue, drops illegal opcodes and
// feeds the L3 cache one command at a time, stalling after a clear until it completes.
module l3_trace_dispatch #(
  parameter int ADDR_BITS   = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 14,
  parameter int TAG_BITS    = ADDR_BITS - INDEX_BITS - OFFSET_BITS,
  parameter int OPR_BITS    = 4,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  l3_trace_dispatch_if.slave   bus
);
  localparam int PTR_BITS = $clog2(FIFO_DEPTH);

  typedef enum logic {ISSUE = 1'b0, WAIT_CLR = 1'b1} state_t;

  state_t                 state_reg;
  logic [PTR_BITS:0]      wr_ptr_reg, rd_ptr_reg;
  logic                   err_reg;
  logic [31:0]            cmd_count_reg;
  logic [15:0]            illegal_count_reg;

  logic [OPR_BITS-1:0]    opr_mem    [FIFO_DEPTH];
  logic [TAG_BITS-1:0]    tag_mem    [FIFO_DEPTH];
  logic [INDEX_BITS-1:0]  index_mem  [FIFO_DEPTH];
  logic [OFFSET_BITS-1:0] offset_mem [FIFO_DEPTH];

  logic full, empty, legal, is_ctl, accept, push, drop, pop, valid;
  logic [PTR_BITS-1:0] wr_slot, rd_slot;
  logic [OPR_BITS-1:0] head_opr;

  assign wr_slot = wr_ptr_reg[PTR_BITS-1:0];
  assign rd_slot = rd_ptr_reg[PTR_BITS-1:0];
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_BITS] != rd_ptr_reg[PTR_BITS]) && (wr_slot == rd_slot);

  assign legal  = (bus.in_opr <= OPR_BITS'(6)) || (bus.in_opr == OPR_BITS'(8)) ||
                  (bus.in_opr == OPR_BITS'(9));
  assign is_ctl = (bus.in_opr == OPR_BITS'(8)) || (bus.in_opr == OPR_BITS'(9));
  assign accept = bus.in_valid && !full;
  assign push   = accept && legal;
  assign drop   = accept && !legal;

  assign valid    = !empty && (state_reg == ISSUE);
  assign pop      = valid && bus.out_ready;
  assign head_opr = opr_mem[rd_slot];

  assign bus.in_ready      = !full;
  assign bus.out_valid     = valid;
  // Payload is forced to zero whenever nothing is being offered, so reset shows zeros.
  assign bus.out_opr       = valid ? head_opr            : '0;
  assign bus.out_tag       = valid ? tag_mem[rd_slot]    : '0;
  assign bus.out_index     = valid ? index_mem[rd_slot]  : '0;
  assign bus.out_offset    = valid ? offset_mem[rd_slot] : '0;
  assign bus.out_is_snoop  = valid && (head_opr >= OPR_BITS'(3)) && (head_opr <= OPR_BITS'(6));
  assign bus.err_opcode    = err_reg;
  assign bus.cmd_count     = cmd_count_reg;
  assign bus.illegal_count = illegal_count_reg;

  // Clear and print carry no address, so their fields are stored as zero.
  always_ff @(posedge clk) begin
    if (push) begin
      opr_mem[wr_slot]    <= bus.in_opr;
      tag_mem[wr_slot]    <= is_ctl ? '0 : bus.in_addr[ADDR_BITS-1 -: TAG_BITS];
      index_mem[wr_slot]  <= is_ctl ? '0 : bus.in_addr[OFFSET_BITS +: INDEX_BITS];
      offset_mem[wr_slot] <= is_ctl ? '0 : bus.in_addr[OFFSET_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      err_reg           <= 1'b0;
      cmd_count_reg     <= '0;
      illegal_count_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      err_reg <= drop;
      if (pop && (cmd_count_reg != '1))
        cmd_count_reg <= cmd_count_reg + 1'b1;
      if (drop && (illegal_count_reg != '1))
        illegal_count_reg <= illegal_count_reg + 1'b1;
    end
  end

  // A clear_done coinciding with the clear handshake is ignored: ISSUE does not look at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ISSUE;
    end else begin
      unique case (state_reg)
        ISSUE:    if (pop && (head_opr == OPR_BITS'(8))) state_reg <= WAIT_CLR;
        WAIT_CLR: if (bus.clear_done) state_reg <= ISSUE;
        default:  state_reg <= ISSUE;
      endcase
    end
  end
endmodule

// File: tb/tb_l3_trace_dispatch.sv
// Self-checking bench for l3_trace_dispatch: directed vector table, hand sequences
// and randomized traffic compared against a queue-based command model.
module tb_l3_trace_dispatch;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l3_trace_dispatch_if bus ();
  l3_trace_dispatch #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0]  opr;
    logic [11:0] tag;
    logic [13:0] index;
    logic [5:0]  offset;
  } cmd_t;

  typedef struct {
    logic [3:0]  opr;
    logic [31:0] addr;
    bit          legal;
    logic [11:0] tag;
    logic [13:0] index;
    logic [5:0]  offset;
    bit          snoop;
  } vec_t;

  cmd_t        mq[$];
  bit          m_wait, m_err;
  bit [31:0]   m_cmd;
  bit [15:0]   m_ill;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [3:0]  seen_opr[$];
  logic        seen_snoop[$];
  logic [3:0]  sent_opr[$];
  vec_t        vt[10];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
    m_err  = 0;
    m_cmd  = 0;
    m_ill  = 0;
  endtask

  task automatic check_model();
    bit mval;
    mval = (mq.size() != 0) && !m_wait;
    cmp("in_ready", 32'(bus.in_ready), 32'(mq.size() < DEPTH));
    cmp("out_valid", 32'(bus.out_valid), 32'(mval));
    if (mval) begin
      cmp("out_opr", 32'(bus.out_opr), 32'(mq[0].opr));
      cmp("out_tag", 32'(bus.out_tag), 32'(mq[0].tag));
      cmp("out_index", 32'(bus.out_index), 32'(mq[0].index));
      cmp("out_offset", 32'(bus.out_offset), 32'(mq[0].offset));
      cmp("out_is_snoop", 32'(bus.out_is_snoop), 32'(mq[0].opr >= 4'd3 && mq[0].opr <= 4'd6));
    end else begin
      cmp("out_is_snoop_idle", 32'(bus.out_is_snoop), 32'd0);
    end
    cmp("err_opcode", 32'(bus.err_opcode), 32'(m_err));
    cmp("cmd_count", bus.cmd_count, m_cmd);
    cmp("illegal_count", 32'(bus.illegal_count), 32'(m_ill));
  endtask

  // One clock: drive inputs, check current outputs against the model, then advance both.
  task automatic step(input bit iv, input logic [3:0] op, input logic [31:0] ad,
                      input bit ordy, input bit cd);
    bit   mrdy, mval, err_n;
    cmd_t c;
    bus.in_valid   = iv;
    bus.in_opr     = op;
    bus.in_addr    = ad;
    bus.out_ready  = ordy;
    bus.clear_done = cd;
    #1;
    check_model();
    if (bus.out_valid && ordy) begin
      seen_opr.push_back(bus.out_opr);
      seen_snoop.push_back(bus.out_is_snoop);
    end
    mrdy  = mq.size() < DEPTH;
    mval  = (mq.size() != 0) && !m_wait;
    err_n = 0;
    @(posedge clk);
    if (mval && ordy) begin
      c = mq.pop_front();
      if (m_cmd != 32'hFFFF_FFFF) m_cmd++;
      if (c.opr == 4'd8) m_wait = 1;
    end else if (m_wait && cd) begin
      m_wait = 0;
    end
    if (iv && mrdy) begin
      if (op <= 4'd6 || op == 4'd8 || op == 4'd9) begin
        c.opr = op;
        if (op >= 4'd8) begin
          c.tag = 0; c.index = 0; c.offset = 0;
        end else begin
          c.tag    = 12'(ad / 32'h0010_0000);
          c.index  = 14'((ad / 64) % 16384);
          c.offset = 6'(ad % 64);
        end
        mq.push_back(c);
        sent_opr.push_back(op);
      end else begin
        err_n = 1;
        if (m_ill != 16'hFFFF) m_ill++;
      end
    end
    m_err = err_n;
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    cmp("rst_out_valid", 32'(bus.out_valid), 32'd0);
    cmp("rst_out_is_snoop", 32'(bus.out_is_snoop), 32'd0);
    bus.in_valid = 0; bus.in_opr = 0; bus.in_addr = 0; bus.out_ready = 0; bus.clear_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    cmp("rst_in_ready", 32'(bus.in_ready), 32'd1);
    cmp("rst_out_opr", 32'(bus.out_opr), 32'd0);
    cmp("rst_out_tag", 32'(bus.out_tag), 32'd0);
    cmp("rst_out_index", 32'(bus.out_index), 32'd0);
    cmp("rst_out_offset", 32'(bus.out_offset), 32'd0);
    cmp("rst_err_opcode", 32'(bus.err_opcode), 32'd0);
    cmp("rst_cmd_count", bus.cmd_count, 32'd0);
    cmp("rst_illegal_count", 32'(bus.illegal_count), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the bench finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{4'd0,  32'h1234_5678, 1'b1, 12'h123, 14'h1159, 6'h38, 1'b0};
    vt[1] = '{4'd1,  32'hFFFF_FFFF, 1'b1, 12'hFFF, 14'h3FFF, 6'h3F, 1'b0};
    vt[2] = '{4'd3,  32'h0000_0040, 1'b1, 12'h000, 14'h0001, 6'h00, 1'b1};
    vt[3] = '{4'd6,  32'h0010_0003, 1'b1, 12'h001, 14'h0000, 6'h03, 1'b1};
    vt[4] = '{4'd9,  32'hDEAD_BEEF, 1'b1, 12'h000, 14'h0000, 6'h00, 1'b0};
    vt[5] = '{4'd7,  32'h0000_1000, 1'b0, 12'h000, 14'h0000, 6'h00, 1'b0};
    vt[6] = '{4'd15, 32'h0BAD_0BAD, 1'b0, 12'h000, 14'h0000, 6'h00, 1'b0};
    vt[7] = '{4'd2,  32'hABC0_0FC1, 1'b1, 12'hABC, 14'h003F, 6'h01, 1'b0};
    vt[8] = '{4'd5,  32'h8000_0000, 1'b1, 12'h800, 14'h0000, 6'h00, 1'b1};
    vt[9] = '{4'd4,  32'h0000_0FFF, 1'b1, 12'h000, 14'h003F, 6'h3F, 1'b1};

    bus.in_valid = 0; bus.in_opr = 0; bus.in_addr = 0; bus.out_ready = 0; bus.clear_done = 0;
    apply_reset();

    // Directed vector table: single command into an empty FIFO, then drained.
    for (int i = 0; i < 10; i++) begin
      step(1, vt[i].opr, vt[i].addr, 0, 0);
      if (vt[i].legal) begin
        cmp($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
        cmp($sformatf("vec%0d_opr", i), 32'(bus.out_opr), 32'(vt[i].opr));
        cmp($sformatf("vec%0d_tag", i), 32'(bus.out_tag), 32'(vt[i].tag));
        cmp($sformatf("vec%0d_index", i), 32'(bus.out_index), 32'(vt[i].index));
        cmp($sformatf("vec%0d_offset", i), 32'(bus.out_offset), 32'(vt[i].offset));
        cmp($sformatf("vec%0d_snoop", i), 32'(bus.out_is_snoop), 32'(vt[i].snoop));
        step(0, 0, 0, 1, 0);
        if (i == 0) cmp("first_cmd_count", bus.cmd_count, 32'd1);
      end else begin
        cmp($sformatf("vec%0d_err", i), 32'(bus.err_opcode), 32'd1);
        cmp($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd0);
        step(0, 0, 0, 0, 0);
      end
    end

    // Fill to capacity with the cache stalled, then drain in order.
    seen_opr.delete(); seen_snoop.delete();
    for (int i = 1; i <= 4; i++) step(1, 4'(i), $urandom, 0, 0);
    cmp("full_in_ready", 32'(bus.in_ready), 32'd0);
    step(1, 4'd5, 32'h5, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);
    cmp("order_count", 32'(seen_opr.size()), 32'd4);
    for (int i = 0; i < 4 && i < seen_opr.size(); i++) begin
      cmp($sformatf("order_opr%0d", i), 32'(seen_opr[i]), 32'(i + 1));
      cmp($sformatf("order_snoop%0d", i), 32'(seen_snoop[i]), 32'(i >= 2));
    end

    // Two illegal opcodes back to back.
    apply_reset();
    step(1, 4'd7, 32'h1, 0, 0);
    cmp("ill7_err", 32'(bus.err_opcode), 32'd1);
    step(1, 4'd12, 32'h2, 0, 0);
    cmp("ill12_err", 32'(bus.err_opcode), 32'd1);
    cmp("ill_valid", 32'(bus.out_valid), 32'd0);
    step(0, 0, 0, 0, 0);
    cmp("ill_err_clear", 32'(bus.err_opcode), 32'd0);
    cmp("ill_count", 32'(bus.illegal_count), 32'd2);

    // Clear command holds dispatch until clear_done.
    step(1, 4'd8, 32'hFFFF_FFFF, 0, 0);
    cmp("clr_opr", 32'(bus.out_opr), 32'd8);
    cmp("clr_tag", 32'(bus.out_tag), 32'd0);
    cmp("clr_index", 32'(bus.out_index), 32'd0);
    cmp("clr_offset", 32'(bus.out_offset), 32'd0);
    step(1, 4'd0, 32'h1234_5678, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cmp($sformatf("clr_hold%0d", i), 32'(bus.out_valid), 32'd0);
      step(0, 0, 0, 1, 0);
    end
    step(0, 0, 0, 1, 1);
    cmp("clr_release_valid", 32'(bus.out_valid), 32'd1);
    cmp("clr_release_opr", 32'(bus.out_opr), 32'd0);
    step(0, 0, 0, 1, 0);

    // clear_done in the same cycle as the clear handshake is ignored.
    step(1, 4'd8, 32'h0, 0, 0);
    step(1, 4'd1, 32'h40, 1, 1);
    step(0, 0, 0, 1, 0);
    cmp("clr_same_cycle_hold", 32'(bus.out_valid), 32'd0);
    step(0, 0, 0, 0, 1);
    cmp("clr_same_cycle_release", 32'(bus.out_valid), 32'd1);
    step(0, 0, 0, 1, 0);

    // Reset with three commands buffered.
    for (int i = 0; i < 3; i++) step(1, 4'd2, $urandom, 0, 0);
    cmp("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    apply_reset();

    // Continuous stream of ten commands.
    seen_opr.delete(); seen_snoop.delete(); sent_opr.delete();
    for (int i = 0; i < 10; i++) begin
      step(1, 4'((i * 3) % 7), $urandom, 1, 0);
      cmp($sformatf("stream_valid%0d", i), 32'(bus.out_valid), 32'd1);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    cmp("stream_count", 32'(seen_opr.size()), 32'd10);
    for (int i = 0; i < 10 && i < seen_opr.size(); i++)
      cmp($sformatf("stream_opr%0d", i), 32'(seen_opr[i]), 32'((i * 3) % 7));
    cmp("stream_cmd_count", bus.cmd_count, 32'd10);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, 4'($urandom % 16), $urandom,
           ($urandom % 3) != 0, ($urandom % 6) == 0);
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
